// File: rtl/moonbase_cpu_4bit.sv
// moonbase_cpu_4bit: nibble-wide accumulator CPU on a multiplexed
// 8-pin bus; every access is an address clock then a data clock.
module moonbase_cpu_4bit #(
  parameter int MAX_COUNT = 1000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam int CW = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((MAX_COUNT > 0) ? MAX_COUNT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE,
    S_OP_A,
    S_OP_D,
    S_N1_A,
    S_N1_D,
    S_N2_A,
    S_N2_D,
    S_MEM_A,
    S_MEM_D
  } state_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] rdata;
  logic [1:0] dev;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign rdata = io_in[5:2];
  assign dev   = io_in[7:6];

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    a;
  logic [3:0]    op;
  logic [3:0]    n1;
  logic [7:0]    x;
  logic [7:0]    y;
  logic [6:0]    pc;
  logic [6:0]    stk [4];
  logic [1:0]    sp;
  logic [1:0]    sp_dec;
  logic [6:0]    base;
  logic [6:0]    ea;

  assign sp_dec = sp - 2'd1;
  // Only the low 7 address bits reach the pins.
  assign base = n1[3] ? y[6:0] : x[6:0];
  assign ea   = base + {4'b0, n1[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (cnt == LAST) nxt = S_OP_A;
      S_OP_A:  nxt = S_OP_D;
      S_OP_D:  nxt = S_N1_A;
      S_N1_A:  nxt = S_N1_D;
      S_N1_D: begin
        if (op >= 4'hC) begin
          nxt = S_N2_A;
        end else if ((op == 4'h7) || (op == 4'h8) ||
                     (op == 4'h9)) begin
          nxt = S_OP_A;
        end else begin
          nxt = S_MEM_A;
        end
      end
      S_N2_A:  nxt = S_N2_D;
      S_N2_D:  nxt = S_OP_A;
      S_MEM_A: nxt = S_MEM_D;
      S_MEM_D: nxt = S_OP_A;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      a   <= '0;
      x   <= '0;
      y   <= '0;
      pc  <= '0;
      sp  <= '0;
      op  <= '0;
      n1  <= '0;
      for (int i = 0; i < 4; i++) stk[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (cnt != LAST) cnt <= cnt + 1'b1;
        S_OP_D: begin
          op <= rdata;
          pc <= pc + 7'd1;
        end
        S_N1_D: begin
          n1 <= rdata;
          pc <= pc + 7'd1;
          case (op)
            4'h7: begin
              case (rdata)
                4'h0: y <= x;
                4'h1: x <= y;
                4'h2: begin
                  x <= y;
                  y <= x;
                end
                4'h3: begin
                  sp <= sp_dec;
                  pc <= stk[sp_dec];
                end
                4'h4: x <= x + 8'd1;
                4'h5: x <= x - 8'd1;
                default: ;
              endcase
            end
            4'h8: a <= rdata;
            4'h9: a <= a + rdata;
            default: ;
          endcase
        end
        S_N2_D: begin
          pc <= pc + 7'd1;
          case (op)
            4'hC: x <= {n1, rdata};
            4'hD: if (a != 4'd0) pc <= {n1[2:0], rdata};
            4'hE: if (a == 4'd0) pc <= {n1[2:0], rdata};
            4'hF: begin
              pc <= {n1[2:0], rdata};
              if (n1[3]) begin
                stk[sp] <= pc + 7'd1;
                sp      <= sp + 2'd1;
              end
            end
            default: ;
          endcase
        end
        S_MEM_D: begin
          case (op)
            4'h0: a <= a + rdata;
            4'h1: a <= a - rdata;
            4'h2: a <= a | rdata;
            4'h3: a <= a & rdata;
            4'h4: a <= a ^ rdata;
            4'h5: a <= rdata;
            4'h6: a <= {2'b00, dev};
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    io_out = 8'h30;
    unique case (state)
      S_OP_A, S_N1_A, S_N2_A: io_out = {1'b1, pc};
      S_MEM_A: io_out = {1'b1, ea};
      S_MEM_D: begin
        unique case (1'b1)
          op == 4'hA: io_out = {4'b0010, a};
          op == 4'hB: io_out = {4'b0001, a};
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_moonbase_cpu_4bit.sv
// Bench for moonbase_cpu_4bit: bus memory on the pins plus an
// instruction-level model predicting every bus clock.
module tb_moonbase_cpu_4bit;
  localparam int MC = 8;

  typedef logic [3:0] nib_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dev = 2'b00;
  logic [3:0] rdata;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [3:0] bmem [128];
  logic [6:0] lat = 7'd0;
  logic [3:0] dwr [$];
  logic [6:0] dadr [$];
  int checks = 0;
  int errors = 0;

  logic [3:0] ma;
  logic [7:0] mx;
  logic [7:0] my;
  logic [6:0] mpc;
  logic [6:0] mstk [4];
  logic [3:0] mvalid;
  logic [1:0] msp;
  logic       mstop;
  logic [3:0] mmem [128];
  logic [7:0] expq [$];

  assign rdata = bmem[lat];
  assign io_in = {dev, rdata, rst_n, clk};

  moonbase_cpu_4bit #(.MAX_COUNT(MC)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  function automatic nib_q_t hexq(input string s);
    nib_q_t q;
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'd48 && c <= 8'd57) q.push_back(4'(c - 8'd48));
      else if (c >= 8'd65 && c <= 8'd70) q.push_back(4'(c - 8'd55));
    end
    return q;
  endfunction

  task automatic load(input logic [3:0] fill);
    for (int i = 0; i < 128; i++) begin
      bmem[i] = fill;
      mmem[i] = fill;
    end
  endtask

  task automatic load_rand();
    logic [3:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 4'($urandom_range(0, 15));
      bmem[i] = v;
      mmem[i] = v;
    end
  endtask

  task automatic poke(input logic [6:0] at, input string s);
    nib_q_t q;
    logic [6:0] ad;
    q = hexq(s);
    for (int i = 0; i < q.size(); i++) begin
      ad = at + 7'(i);
      bmem[ad] = q[i];
      mmem[ad] = q[i];
    end
  endtask

  // One bus clock: sample at the falling edge, act as memory/device.
  task automatic cycle();
    @(negedge clk);
    if (io_out[7]) begin
      lat = io_out[6:0];
    end else begin
      if (!io_out[5]) bmem[lat] = io_out[3:0];
      if (!io_out[4]) begin
        dwr.push_back(io_out[3:0]);
        dadr.push_back(lat);
      end
    end
  endtask

  task automatic m_fetch(output logic [3:0] v);
    expq.push_back({1'b1, mpc});
    expq.push_back(8'h30);
    v = mmem[mpc];
    mpc = mpc + 7'd1;
  endtask

  task automatic m_access(input logic [3:0] m, input logic [7:0] dph,
                          output logic [6:0] ad);
    logic [7:0] b;
    logic [7:0] e;
    b = m[3] ? my : mx;
    e = b + {5'b0, m[2:0]};
    ad = e[6:0];
    expq.push_back({1'b1, ad});
    expq.push_back(dph);
  endtask

  task automatic m_step();
    logic [3:0] op;
    logic [3:0] n;
    logic [3:0] l;
    logic [3:0] v;
    logic [6:0] ad;
    logic [7:0] t;
    m_fetch(op);
    m_fetch(n);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        m_access(n, 8'h30, ad);
        v = mmem[ad];
        case (op)
          4'h0: ma = ma + v;
          4'h1: ma = ma - v;
          4'h2: ma = ma | v;
          4'h3: ma = ma & v;
          4'h4: ma = ma ^ v;
          4'h5: ma = v;
          default: ma = {2'b00, dev};
        endcase
      end
      4'h7: begin
        case (n)
          4'h0: my = mx;
          4'h1: mx = my;
          4'h2: begin
            t = mx;
            mx = my;
            my = t;
          end
          4'h3: begin
            msp = msp - 2'd1;
            if (mvalid[msp]) mpc = mstk[msp];
            else mstop = 1'b1;
          end
          4'h4: mx = mx + 8'd1;
          4'h5: mx = mx - 8'd1;
          default: ;
        endcase
      end
      4'h8: ma = n;
      4'h9: ma = ma + n;
      4'hA: m_access(n, {4'b0010, ma}, ad);
      4'hB: begin
        m_access(n, {4'b0001, ma}, ad);
        mmem[ad] = ma;
      end
      default: begin
        m_fetch(l);
        case (op)
          4'hC: mx = {n, l};
          4'hD: if (ma != 4'd0) mpc = {n[2:0], l};
          4'hE: if (ma == 4'd0) mpc = {n[2:0], l};
          default: begin
            if (n[3]) begin
              mstk[msp] = mpc;
              mvalid[msp] = 1'b1;
              msp = msp + 2'd1;
            end
            mpc = {n[2:0], l};
          end
        endcase
      end
    endcase
  endtask

  task automatic start();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io_out !== 8'h30) begin
      errors++;
      $display("FAIL reset_out io_out=%h expected 30", io_out);
    end
    ma = '0; mx = '0; my = '0; mpc = '0; msp = '0;
    mvalid = '0; mstop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MC - 1; i++) begin
      cycle();
      checks++;
      if (io_out !== 8'h30) begin
        errors++;
        $display("FAIL idle clk %0d io_out=%h expected 30", i, io_out);
      end
    end
    dwr.delete();
    dadr.delete();
    expq.delete();
  endtask

  task automatic run(input int ninstr, input string tag);
    logic [7:0] e;
    for (int i = 0; i < ninstr; i++) begin
      m_step();
      while (expq.size() > 0) begin
        e = expq.pop_front();
        cycle();
        checks++;
        if (io_out !== e) begin
          errors++;
          $display("FAIL %s bus instr %0d io_out=%h expected %h",
                   tag, i, io_out, e);
          expq.delete();
          return;
        end
      end
      if (mstop) return;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (io_out !== 8'h30) begin
      errors++;
      $display("FAIL por_out io_out=%h expected 30", io_out);
    end
    load(4'h7);
    poke(7'h00, "85 A7");
    start();
    cycle();
    checks++;
    if (io_out !== 8'h80) begin
      errors++;
      $display("FAIL first_fetch io_out=%h expected 80", io_out);
    end
  endtask

  task automatic test_count_loop();
    load(4'h7);
    poke(7'h00, "80 CF0 A7 B0 81 00 D05");
    start();
    run(86, "count");
    checks++;
    if (dwr.size() != 16) begin
      errors++;
      $display("FAIL count_len got %0d expected 16", dwr.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (dwr[i] !== 4'(i) || dadr[i] !== 7'h77) begin
          errors++;
          $display("FAIL count_wr %0d got %h@%h expected %h@77",
                   i, dwr[i], dadr[i], 4'(i));
        end
      end
    end
    checks++;
    if (bmem[7'h70] !== 4'hF) begin
      errors++;
      $display("FAIL count_mem got %h expected F", bmem[7'h70]);
    end
  endtask

  task automatic test_alu();
    nib_q_t ex;
    load(4'h7);
    poke(7'h00, "8A CF0 B0 8C10A7 8C20A7 8C30A7 8C40A7");
    start();
    run(15, "alu");
    ex = hexq("2E86");
    checks++;
    if (dwr.size() != ex.size()) begin
      errors++;
      $display("FAIL alu_len got %0d expected %0d", dwr.size(), ex.size());
    end else begin
      for (int i = 0; i < ex.size(); i++) begin
        checks++;
        if (dwr[i] !== ex[i]) begin
          errors++;
          $display("FAIL alu_wr %0d got %h expected %h", i, dwr[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_index_regs();
    nib_q_t ex;
    load(4'h7);
    poke(7'h00, "C20 70 58 A7 59 A7");
    poke(7'h20, "8C");
    start();
    run(6, "xy");
    ex = hexq("8C");
    checks++;
    if (dwr.size() != ex.size()) begin
      errors++;
      $display("FAIL xy_len got %0d expected %0d", dwr.size(), ex.size());
    end else begin
      for (int i = 0; i < ex.size(); i++) begin
        checks++;
        if (dwr[i] !== ex[i] || dadr[i] !== 7'h27) begin
          errors++;
          $display("FAIL xy_wr %0d got %h@%h expected %h@27",
                   i, dwr[i], dadr[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_call();
    nib_q_t ex;
    load(4'h7);
    poke(7'h00, "8C FC9 80 A7");
    poke(7'h49, "91 A7 FDC 91 A7 73");
    poke(7'h5C, "91 A7 73");
    start();
    run(13, "call");
    ex = hexq("DEF0");
    checks++;
    if (dwr.size() != ex.size()) begin
      errors++;
      $display("FAIL call_len got %0d expected %0d", dwr.size(), ex.size());
    end else begin
      for (int i = 0; i < ex.size(); i++) begin
        checks++;
        if (dwr[i] !== ex[i]) begin
          errors++;
          $display("FAIL call_wr %0d got %h expected %h", i, dwr[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_write_phase();
    load(4'h7);
    poke(7'h00, "CF0 86 B0 A7");
    start();
    run(2, "wr");
    repeat (4) cycle();
    cycle();
    checks++;
    if (io_out !== 8'hF0) begin
      errors++;
      $display("FAIL memwr_addr io_out=%h expected F0", io_out);
    end
    cycle();
    checks++;
    if (io_out !== 8'h16) begin
      errors++;
      $display("FAIL memwr_data io_out=%h expected 16", io_out);
    end
    repeat (4) cycle();
    cycle();
    checks++;
    if (io_out !== 8'hF7) begin
      errors++;
      $display("FAIL devwr_addr io_out=%h expected F7", io_out);
    end
    cycle();
    checks++;
    if (io_out !== 8'h26) begin
      errors++;
      $display("FAIL devwr_data io_out=%h expected 26", io_out);
    end
    checks++;
    if (bmem[7'h70] !== 4'h6) begin
      errors++;
      $display("FAIL memwr_cell got %h expected 6", bmem[7'h70]);
    end
  endtask

  task automatic test_mid_reset();
    load(4'h7);
    poke(7'h00, "80 CF0 A7 B0 81 00 D05");
    start();
    run(20, "pre_rst");
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io_out !== 8'h30) begin
      errors++;
      $display("FAIL midrst_out io_out=%h expected 30", io_out);
    end
    dwr.delete();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (io_out !== 8'h30) begin
        errors++;
        $display("FAIL midrst_hold %0d io_out=%h expected 30", i, io_out);
      end
    end
    checks++;
    if (dwr.size() != 0) begin
      errors++;
      $display("FAIL midrst_wr got %0d writes expected 0", dwr.size());
    end
    load(4'h7);
    poke(7'h00, "80 CF0 A7 B0 81 00 D05");
    start();
    run(12, "post_rst");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      load_rand();
      dev = 2'($urandom_range(0, 3));
      start();
      run(250, "random");
    end
  endtask

  initial begin
    test_reset();
    test_count_loop();
    test_alu();
    test_index_regs();
    test_call();
    test_write_phase();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
